// File: rtl/lsu.sv
// Load/store unit: combinational loads, single-edge stores, little-endian
// byte lanes over DMEM and memory-mapped I/O registers.
//
// Ports:
//   i_clk, i_reset      clock, async active-high reset
//   i_lsu_addr          byte address
//   i_st_data           store data (low byte/halfword for narrow stores)
//   i_lsu_wren          1 = store this cycle
//   i_funct3            access type / width
//   o_ld_data           load result (sign/zero extended)
//   o_misaligned        misaligned access or illegal funct3
//   o_io_ledr..o_io_lcd output peripheral registers
//   i_io_sw, i_io_btn   asynchronous switch / button inputs
module lsu #(
    parameter int DMEM_BYTES = 2048
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_ld_data,
    output logic        o_misaligned,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [31:0] o_io_hexl,
    output logic [31:0] o_io_hexh,
    output logic [31:0] o_io_lcd,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn
);
    localparam int AW    = $clog2(DMEM_BYTES);
    localparam int WORDS = DMEM_BYTES / 4;

    logic [31:0] dmem_q [WORDS];
    logic [31:0] dmem_d;
    logic [31:0] ledr_q, ledr_d, ledg_q, ledg_d;
    logic [31:0] hexl_q, hexl_d, hexh_q, hexh_d;
    logic [31:0] lcd_q, lcd_d;
    logic [31:0] sw_s1_q, sw_s2_q;
    logic [3:0]  btn_s1_q, btn_s2_q;

    logic [1:0]    lane;
    logic [1:0]    size;
    logic          illegal;
    logic          misaligned;
    logic [19:0]   page;
    logic [AW-3:0] widx;
    logic          sel_dmem, sel_ledr, sel_ledg, sel_hexl;
    logic          sel_hexh, sel_lcd, sel_sw, sel_btn;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          wr_en;
    logic          dmem_we;
    logic [31:0]   rword;
    logic [7:0]    bsel;
    logic [15:0]   hsel;
    logic [31:0]   ld_data;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] nw,
        input logic [3:0]  en
    );
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = en[b] ? nw[8*b +: 8] : old[8*b +: 8];
        end
        return res;
    endfunction

    assign lane = i_lsu_addr[1:0];
    assign size = i_funct3[1:0];
    assign page = i_lsu_addr[31:12];
    assign widx = i_lsu_addr[AW-1:2];

    // 011, 110 and 111 are the only funct3 values without a defined access
    assign illegal = (size == 2'b11) || (i_funct3 == 3'b110);

    always_comb begin
        misaligned = illegal;
        unique case (size)
            2'b00:   misaligned = illegal;
            2'b01:   misaligned = illegal | lane[0];
            default: misaligned = illegal | (lane != 2'b00);
        endcase
    end

    assign sel_dmem = (i_lsu_addr[31:AW] == '0);
    assign sel_ledr = (page == 20'h10000);
    assign sel_ledg = (page == 20'h10001);
    assign sel_hexl = (page == 20'h10002);
    assign sel_hexh = (page == 20'h10003);
    assign sel_lcd  = (page == 20'h10004);
    assign sel_sw   = (page == 20'h10010);
    assign sel_btn  = (page == 20'h10011);

    // Narrow store data is replicated so every enabled lane sees it
    always_comb begin
        be    = 4'b1111;
        wdata = i_st_data;
        unique case (size)
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << lane;
                wdata = {2{i_st_data[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    assign wr_en   = i_lsu_wren & ~misaligned;
    assign dmem_we = wr_en & sel_dmem & ~i_reset;
    assign dmem_d  = merge(dmem_q[widx], wdata, be);

    always_comb begin
        ledr_d = ledr_q;
        ledg_d = ledg_q;
        hexl_d = hexl_q;
        hexh_d = hexh_q;
        lcd_d  = lcd_q;
        if (wr_en) begin
            if (sel_ledr) ledr_d = merge(ledr_q, wdata, be);
            if (sel_ledg) ledg_d = merge(ledg_q, wdata, be);
            if (sel_hexl) hexl_d = merge(hexl_q, wdata, be);
            if (sel_hexh) hexh_d = merge(hexh_q, wdata, be);
            if (sel_lcd)  lcd_d  = merge(lcd_q, wdata, be);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ledr_q   <= '0;
            ledg_q   <= '0;
            hexl_q   <= '0;
            hexh_q   <= '0;
            lcd_q    <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
        end else begin
            ledr_q   <= ledr_d;
            ledg_q   <= ledg_d;
            hexl_q   <= hexl_d;
            hexh_q   <= hexh_d;
            lcd_q    <= lcd_d;
            sw_s1_q  <= i_io_sw;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= i_io_btn;
            btn_s2_q <= btn_s1_q;
        end
    end

    // DMEM is deliberately left out of reset so contents survive it
    always_ff @(posedge i_clk) begin
        if (dmem_we) begin
            dmem_q[widx] <= dmem_d;
        end
    end

    always_comb begin
        rword = '0;
        unique case (1'b1)
            sel_dmem: rword = dmem_q[widx];
            sel_ledr: rword = ledr_q;
            sel_ledg: rword = ledg_q;
            sel_hexl: rword = hexl_q;
            sel_hexh: rword = hexh_q;
            sel_lcd:  rword = lcd_q;
            sel_sw:   rword = sw_s2_q;
            sel_btn:  rword = {28'd0, btn_s2_q};
            default:  rword = '0;
        endcase
    end

    assign bsel = rword[{lane, 3'b000} +: 8];
    assign hsel = rword[{lane[1], 4'b0000} +: 16];

    // funct3[2] selects zero extension for LBU/LHU
    always_comb begin
        ld_data = rword;
        unique case (size)
            2'b00:   ld_data = {{24{~i_funct3[2] & bsel[7]}}, bsel};
            2'b01:   ld_data = {{16{~i_funct3[2] & hsel[15]}}, hsel};
            default: ld_data = rword;
        endcase
        if (misaligned) begin
            ld_data = '0;
        end
    end

    assign o_ld_data    = ld_data;
    assign o_misaligned = misaligned;
    assign o_io_ledr    = ledr_q;
    assign o_io_ledg    = ledg_q;
    assign o_io_hexl    = hexl_q;
    assign o_io_hexh    = hexh_q;
    assign o_io_lcd     = lcd_q;
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: vector table through a scoreboard queue,
// plus hand sequences for synchronizers and asynchronous reset.
module tb_lsu;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [31:0] i_lsu_addr = '0;
    logic [31:0] i_st_data = '0;
    logic        i_lsu_wren = 1'b0;
    logic [2:0]  i_funct3 = 3'b010;
    logic [31:0] o_ld_data;
    logic        o_misaligned;
    logic [31:0] o_io_ledr, o_io_ledg, o_io_hexl, o_io_hexh, o_io_lcd;
    logic [31:0] i_io_sw = '0;
    logic [3:0]  i_io_btn = '0;

    always #5 i_clk = ~i_clk;

    lsu #(.DMEM_BYTES(2048)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_lsu_addr   (i_lsu_addr),
        .i_st_data    (i_st_data),
        .i_lsu_wren   (i_lsu_wren),
        .i_funct3     (i_funct3),
        .o_ld_data    (o_ld_data),
        .o_misaligned (o_misaligned),
        .o_io_ledr    (o_io_ledr),
        .o_io_ledg    (o_io_ledg),
        .o_io_hexl    (o_io_hexl),
        .o_io_hexh    (o_io_hexh),
        .o_io_lcd     (o_io_lcd),
        .i_io_sw      (i_io_sw),
        .i_io_btn     (i_io_btn)
    );

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010;
    localparam logic [2:0] LBU = 3'b100, LHU = 3'b101;

    typedef struct packed {
        logic        wren;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
        logic        mis;
    } vec_t;

    typedef struct packed {
        logic        chk;
        logic [31:0] exp;
        logic        mis;
        logic [15:0] id;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic w, input logic [2:0] f,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic c, input logic [31:0] e,
                                input logic m);
        vec_t v;
        v.wren = w; v.f3 = f; v.addr = a; v.wdata = d;
        v.chk = c; v.exp = e; v.mis = m;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int id);
        exp_t e;
        @(posedge i_clk);
        #1;
        i_lsu_wren = v.wren;
        i_funct3   = v.f3;
        i_lsu_addr = v.addr;
        i_st_data  = v.wdata;
        sb.push_back({v.chk, v.exp, v.mis, 16'(id)});
        @(negedge i_clk);
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL vec%0d: scoreboard empty", id);
        end else begin
            e = sb.pop_front();
            check($sformatf("vec%0d mis", e.id), {31'd0, o_misaligned},
                  {31'd0, e.mis});
            if (e.chk) begin
                check($sformatf("vec%0d data", e.id), o_ld_data, e.exp);
            end
        end
    endtask

    task automatic check_io_zero(input string nm);
        check({nm, " ledr"}, o_io_ledr, 32'h0);
        check({nm, " ledg"}, o_io_ledg, 32'h0);
        check({nm, " hexl"}, o_io_hexl, 32'h0);
        check({nm, " hexh"}, o_io_hexh, 32'h0);
        check({nm, " lcd"}, o_io_lcd, 32'h0);
    endtask

    initial begin
        vecs.push_back(mk(1, LW, 32'h10, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk(0, LW, 32'h10, 0, 1, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, LBU, 32'h13, 0, 1, 32'h000000DE, 0));
        vecs.push_back(mk(0, LB, 32'h11, 0, 1, 32'hFFFFFFBE, 0));
        vecs.push_back(mk(0, LHU, 32'h12, 0, 1, 32'h0000DEAD, 0));
        vecs.push_back(mk(0, LH, 32'h12, 0, 1, 32'hFFFFDEAD, 0));
        vecs.push_back(mk(0, LBU, 32'h10, 0, 1, 32'h000000EF, 0));
        vecs.push_back(mk(1, LW, 32'h20, 32'h0, 0, 0, 0));
        vecs.push_back(mk(1, LB, 32'h21, 32'h12345680, 0, 0, 0));
        vecs.push_back(mk(0, LW, 32'h20, 0, 1, 32'h00008000, 0));
        vecs.push_back(mk(0, LH, 32'h20, 0, 1, 32'hFFFF8000, 0));
        vecs.push_back(mk(0, LHU, 32'h20, 0, 1, 32'h00008000, 0));
        vecs.push_back(mk(1, LW, 32'h30, 32'h11223344, 0, 0, 0));
        vecs.push_back(mk(1, LH, 32'h31, 32'h0000FFFF, 1, 0, 1));
        vecs.push_back(mk(0, LW, 32'h30, 0, 1, 32'h11223344, 0));
        vecs.push_back(mk(0, LW, 32'h32, 0, 1, 32'h0, 1));
        vecs.push_back(mk(1, LH, 32'h32, 32'hAAAA5566, 0, 0, 0));
        vecs.push_back(mk(0, LW, 32'h30, 0, 1, 32'h55663344, 0));
        vecs.push_back(mk(1, LB, 32'h33, 32'h000000F0, 0, 0, 0));
        vecs.push_back(mk(0, LB, 32'h33, 0, 1, 32'hFFFFFFF0, 0));
        vecs.push_back(mk(0, LW, 32'h30, 0, 1, 32'hF0663344, 0));
        vecs.push_back(mk(1, LW, 32'h0, 32'h01020304, 0, 0, 0));
        vecs.push_back(mk(0, LW, 32'h20000000, 0, 1, 32'h0, 0));
        vecs.push_back(mk(1, LW, 32'h20000000, 32'hCAFEF00D, 0, 0, 0));
        vecs.push_back(mk(0, LW, 32'h20000000, 0, 1, 32'h0, 0));
        vecs.push_back(mk(0, LW, 32'h0, 0, 1, 32'h01020304, 0));
        vecs.push_back(mk(0, 3'b011, 32'h10, 0, 1, 32'h0, 1));
        vecs.push_back(mk(0, 3'b110, 32'h10, 0, 1, 32'h0, 1));
        vecs.push_back(mk(0, 3'b111, 32'h10, 0, 1, 32'h0, 1));
        vecs.push_back(mk(1, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1));
        vecs.push_back(mk(0, LW, 32'h10, 0, 1, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, LW, 32'h7FC, 32'hA5A5A5A5, 0, 0, 0));
        vecs.push_back(mk(0, LW, 32'h7FC, 0, 1, 32'hA5A5A5A5, 0));
        vecs.push_back(mk(0, LW, 32'h800, 0, 1, 32'h0, 0));
        vecs.push_back(mk(1, LW, 32'h800, 32'h12345678, 0, 0, 0));
        vecs.push_back(mk(0, LW, 32'h0, 0, 1, 32'h01020304, 0));
        vecs.push_back(mk(1, LW, 32'h10000000, 32'h000000FF, 0, 0, 0));
        vecs.push_back(mk(0, LW, 32'h10000000, 0, 1, 32'h000000FF, 0));
        vecs.push_back(mk(1, LB, 32'h10000002, 32'h0000005A, 0, 0, 0));
        vecs.push_back(mk(0, LW, 32'h10000000, 0, 1, 32'h005A00FF, 0));
        vecs.push_back(mk(0, LBU, 32'h10000002, 0, 1, 32'h0000005A, 0));
        vecs.push_back(mk(1, LW, 32'h10001000, 32'h12345678, 0, 0, 0));
        vecs.push_back(mk(1, LH, 32'h10001002, 32'h0000BEEF, 0, 0, 0));
        vecs.push_back(mk(0, LW, 32'h10001FFC, 0, 1, 32'hBEEF5678, 0));
        vecs.push_back(mk(0, LH, 32'h10001002, 0, 1, 32'hFFFFBEEF, 0));
        vecs.push_back(mk(1, LW, 32'h10002000, 32'h11111111, 0, 0, 0));
        vecs.push_back(mk(1, LW, 32'h10003000, 32'h22222222, 0, 0, 0));
        vecs.push_back(mk(1, LW, 32'h10004000, 32'h33333333, 0, 0, 0));
        vecs.push_back(mk(1, LH, 32'h10004002, 32'h00008888, 0, 0, 0));
        vecs.push_back(mk(0, LW, 32'h10004000, 0, 1, 32'h88883333, 0));
        vecs.push_back(mk(0, LW, 32'h10005000, 0, 1, 32'h0, 0));
        vecs.push_back(mk(1, LW, 32'h10000001, 32'hFFFFFFFF, 1, 0, 1));

        // reset state
        @(posedge i_clk);
        #1;
        check_io_zero("reset");
        i_lsu_addr = 32'h10010000;
        #1;
        check("reset sw", o_ld_data, 32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i], i);

        @(posedge i_clk);
        #1;
        i_lsu_wren = 1'b0;
        check("out ledr", o_io_ledr, 32'h005A00FF);
        check("out ledg", o_io_ledg, 32'hBEEF5678);
        check("out hexl", o_io_hexl, 32'h11111111);
        check("out hexh", o_io_hexh, 32'h22222222);
        check("out lcd", o_io_lcd, 32'h88883333);

        // switch/button synchronizers: two edges of latency
        i_funct3   = LW;
        i_lsu_addr = 32'h10010000;
        i_io_sw    = 32'h00000ABC;
        i_io_btn   = 4'hB;
        @(negedge i_clk);
        check("sw 0 edges", o_ld_data, 32'h0);
        @(negedge i_clk);
        check("sw 1 edge", o_ld_data, 32'h0);
        @(negedge i_clk);
        check("sw 2 edges", o_ld_data, 32'h00000ABC);
        i_lsu_addr = 32'h10011000;
        #1;
        check("btn", o_ld_data, 32'h0000000B);
        i_funct3   = LBU;
        i_lsu_addr = 32'h10010001;
        #1;
        check("sw lbu", o_ld_data, 32'h0000000A);
        @(posedge i_clk);
        #1;
        i_lsu_wren = 1'b1;
        i_funct3   = LW;
        i_lsu_addr = 32'h10010000;
        i_st_data  = 32'h1;
        @(posedge i_clk);
        #1;
        i_lsu_addr = 32'h10011000;
        i_st_data  = 32'hF;
        @(posedge i_clk);
        #1;
        i_lsu_wren = 1'b0;
        i_lsu_addr = 32'h10010000;
        #1;
        check("sw ro", o_ld_data, 32'h00000ABC);
        i_lsu_addr = 32'h10011000;
        #1;
        check("btn ro", o_ld_data, 32'h0000000B);

        // async reset mid-cycle with a store pending
        @(posedge i_clk);
        #1;
        i_lsu_wren = 1'b1;
        i_lsu_addr = 32'h10000000;
        i_st_data  = 32'h00000033;
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        check_io_zero("async rst");
        check("rst ld ledr", o_ld_data, 32'h0);
        @(posedge i_clk);
        #1;
        check("rst st drop", o_io_ledr, 32'h0);
        i_lsu_addr = 32'h10010000;
        i_lsu_wren = 1'b0;
        #1;
        check("rst sync clr", o_ld_data, 32'h0);
        i_lsu_addr = 32'h10;
        #1;
        check("rst dmem keep", o_ld_data, 32'hDEADBEEF);
        @(negedge i_clk);
        i_reset    = 1'b0;
        i_lsu_wren = 1'b1;
        i_lsu_addr = 32'h10000000;
        i_st_data  = 32'h00000077;
        @(posedge i_clk);
        #1;
        check("first st", o_io_ledr, 32'h00000077);
        check("hexl cleared", o_io_hexl, 32'h0);
        i_lsu_wren = 1'b0;
        i_lsu_addr = 32'h10;
        #1;
        check("dmem after", o_ld_data, 32'hDEADBEEF);
        i_lsu_addr = 32'h10010000;
        @(negedge i_clk);
        @(negedge i_clk);
        check("sw resync", o_ld_data, 32'h00000ABC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
